// File: rtl/btn_pkg.sv
// Shared constants for the button event classifier: state codes,
// default 100 MHz timing and the default counter width.
package btn_pkg;

    localparam int CNT_W = 27;

    // Default timing at 100 MHz.
    localparam int LONG_CYC_DEF   = 100_000_000;  // 1 s hold
    localparam int DCLICK_CYC_DEF = 30_000_000;   // 300 ms double-click window
    localparam int REPEAT_CYC_DEF = 20_000_000;   // 200 ms auto-repeat period

    // State encoding, also visible on state_o for debug.
    localparam logic [2:0] ST_IDLE           = 3'd0;
    localparam logic [2:0] ST_PRESSED        = 3'd1;
    localparam logic [2:0] ST_LONG_HELD      = 3'd2;
    localparam logic [2:0] ST_WAIT_SECOND    = 3'd3;
    localparam logic [2:0] ST_SECOND_PRESSED = 3'd4;

endpackage

// File: rtl/btn_event_classifier.sv
// Classifies a debounced button level into short press, double click,
// long press and auto-repeat events, each a registered one-cycle pulse.
// Every pulse is registered in the cycle that decides it, so it is seen
// one cycle later and lasts exactly one cycle. At most one pulse is high
// in any cycle.
module btn_event_classifier #(
    parameter int LONG_CYC   = btn_pkg::LONG_CYC_DEF,
    parameter int DCLICK_CYC = btn_pkg::DCLICK_CYC_DEF,
    parameter int REPEAT_CYC = btn_pkg::REPEAT_CYC_DEF,
    parameter bit REPEAT_EN  = 1'b1,
    parameter int CNT_W      = btn_pkg::CNT_W
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       btn_in,
    output logic       short_press,
    output logic       double_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic [2:0] state_o
);
    import btn_pkg::*;

    // Terminal counts: each timed state fires when the counter reaches N-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q;
    logic             rise;
    logic             rep_restart;
    logic             short_d, dbl_d, long_d, rep_d;
    logic             short_q, dbl_q, long_q, rep_q;

    // btn_prev resets high so a button held through reset needs a fresh press.
    assign rise = btn_in & ~btn_prev_q;

    // State, counter, edge-detect and pulse registers.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b1;
            short_q    <= 1'b0;
            dbl_q      <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_in;
            short_q    <= short_d;
            dbl_q      <= dbl_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
        end
    end

    // Next-state logic; release/press always wins over a coincident timeout.
    always_comb begin
        state_d     = state_q;
        rep_restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!btn_in)                 state_d = ST_WAIT_SECOND;
                else if (cnt_q == LONG_LAST) state_d = ST_LONG_HELD;
            end
            ST_LONG_HELD: begin
                if (!btn_in)                                 state_d = ST_IDLE;
                else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) rep_restart = 1'b1;
            end
            ST_WAIT_SECOND: begin
                if (btn_in)                    state_d = ST_SECOND_PRESSED;
                else if (cnt_q == DCLICK_LAST) state_d = ST_IDLE;
            end
            ST_SECOND_PRESSED: begin
                if (!btn_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cycle counter: cleared on state entry and on each repeat, counts in timed states.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || rep_restart) begin
            cnt_d = '0;
        end else if (((state_q == ST_PRESSED) || (state_q == ST_LONG_HELD) ||
                      (state_q == ST_WAIT_SECOND)) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode: which event the current cycle decides, if any.
    always_comb begin
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            ST_PRESSED:     long_d  = btn_in && (cnt_q == LONG_LAST);
            ST_LONG_HELD:   rep_d   = rep_restart;
            ST_WAIT_SECOND: begin
                dbl_d   = btn_in;
                short_d = !btn_in && (cnt_q == DCLICK_LAST);
            end
            default: ;
        endcase
    end

    assign short_press  = short_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_btn_event_classifier.sv
// Testbench for btn_event_classifier with small timing parameters.
// A timestamp-based reference model predicts each cycle's pulses and
// state; directed scenarios also check absolute pulse cycles.
module tb_btn_event_classifier;

    localparam int LONG = 10;
    localparam int DCL  = 6;
    localparam int REP  = 4;

    logic       clk_100MHz = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;
    logic       short_press, double_click, long_press, repeat_pulse;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus the cycle at which the phase's timing began.
    int m_mode = 0;   // 0 idle, 1 first held, 2 long held, 3 gap, 4 second held
    int m_mark = 0;
    int m_t    = 0;
    bit m_prev = 1'b1;

    // Per-scenario event log.
    int tcyc;
    int n_s, n_d, n_l, n_r;
    int s_at, d_at, l_at, r_first, r_last;

    btn_event_classifier #(
        .LONG_CYC   (LONG),
        .DCLICK_CYC (DCL),
        .REPEAT_CYC (REP),
        .REPEAT_EN  (1'b1)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .rst          (rst),
        .btn_in       (btn_in),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .state_o      (state_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, predict, clock, compare.
    task automatic step(input logic b, input logic r);
        logic       e_s, e_d, e_l, e_r;
        logic [2:0] e_st;
        logic       onehot;
        e_s = 1'b0; e_d = 1'b0; e_l = 1'b0; e_r = 1'b0;
        btn_in = b;
        rst    = r;
        if (r) begin
            m_mode = 0;
            m_prev = 1'b1;
        end else begin
            case (m_mode)
                0: if (b && !m_prev) begin m_mode = 1; m_mark = m_t; end
                1: begin
                    if (!b) begin m_mode = 3; m_mark = m_t; end
                    else if (m_t - m_mark == LONG) begin e_l = 1'b1; m_mode = 2; m_mark = m_t; end
                end
                2: begin
                    if (!b) m_mode = 0;
                    else if (((m_t - m_mark) % REP) == 0) e_r = 1'b1;
                end
                3: begin
                    if (b) begin e_d = 1'b1; m_mode = 4; end
                    else if (m_t - m_mark == DCL) begin e_s = 1'b1; m_mode = 0; end
                end
                default: if (!b) m_mode = 0;
            endcase
            m_prev = b;
        end
        e_st = 3'(m_mode);
        @(posedge clk_100MHz);
        #1;
        m_t++;
        tcyc++;
        chk("short_press", 32'(short_press), 32'(e_s));
        chk("double_click", 32'(double_click), 32'(e_d));
        chk("long_press", 32'(long_press), 32'(e_l));
        chk("repeat_pulse", 32'(repeat_pulse), 32'(e_r));
        chk("state_o", 32'(state_o), 32'(e_st));
        onehot = ($countones({short_press, double_click, long_press, repeat_pulse}) <= 1);
        chk("exclusive", 32'(onehot), 32'd1);
        if (short_press === 1'b1)  begin n_s++; s_at = tcyc; end
        if (double_click === 1'b1) begin n_d++; d_at = tcyc; end
        if (long_press === 1'b1)   begin n_l++; l_at = tcyc; end
        if (repeat_pulse === 1'b1) begin
            n_r++;
            if (n_r == 1) r_first = tcyc;
            r_last = tcyc;
        end
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // Quiet the button, then start a scenario at cycle 0.
    task automatic begin_sc();
        hold(1'b0, 20);
        tcyc = 0;
        n_s = 0; n_d = 0; n_l = 0; n_r = 0;
        s_at = -1; d_at = -1; l_at = -1; r_first = -1; r_last = -1;
    endtask

    initial begin
        int len;
        logic lvl;

        // Reset with button low.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("reset_state", 32'(state_o), 32'd0);

        // Short press: high 0-2.
        begin_sc();
        hold(1'b1, 3); hold(1'b0, 12);
        chk("short_at", s_at, 10);
        chk("short_others", n_d + n_l + n_r, 0);

        // Double click.
        begin_sc();
        hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 5);
        chk("dbl_at", d_at, 7);
        chk("dbl_no_short", n_s, 0);

        // Long press with repeats.
        begin_sc();
        hold(1'b1, 26); hold(1'b0, 12);
        chk("long_at", l_at, 11);
        chk("rep_count", n_r, 3);
        chk("rep_first", r_first, 15);
        chk("rep_last", r_last, 23);
        chk("long_no_short", n_s, 0);

        // Release on the terminal count.
        begin_sc();
        hold(1'b1, 10); hold(1'b0, 10);
        chk("term_no_long", n_l, 0);
        chk("term_short_at", s_at, 17);

        // Held through reset.
        begin_sc();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        hold(1'b1, 26);
        chk("held_rst_quiet", n_s + n_d + n_l + n_r, 0);
        hold(1'b0, 3); hold(1'b1, 15);
        chk("held_rst_long_at", l_at, 45);
        hold(1'b0, 10);

        // Reset in the double-click window.
        begin_sc();
        hold(1'b1, 3); hold(1'b0, 3); step(1'b0, 1'b1); hold(1'b0, 10);
        chk("midwin_no_short", n_s, 0);

        // Random bursts with occasional reset, checked against the model.
        for (int k = 0; k < 250; k++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 30))
                                              : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++)
                step(lvl, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
